reg_file_32x32: RTL and testbench

- RV32 integer register file: 32 entries of D_WIDTH bits, two read ports and one write port.
- x0 is hardwired to zero.
- Reads are registered: one-cycle latency, gated by regLd.
- Sits between decode (rs1/rs2/rd fields) and the execute/write-back stages.

---
 rtl/reg_file_32x32_pkg.sv | 17 +
 rtl/reg_file_32x32_if.sv | 39 +++
 rtl/reg_file_32x32_read_port.sv | 45 ++++
 rtl/reg_file_32x32.sv | 95 +++++++++
 tb/tb_reg_file_32x32.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/reg_file_32x32_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_32x32_pkg
// Shared constants and types for the RV32 integer register file.
//   REG_ADDR_W : width of a register specifier (rs1/rs2/rd fields)
//   NUM_REGS   : number of architectural registers (x0..x31)
//   XLEN       : integer register width, default data width of the file
//   reg_addr_t : register specifier type
// ----------------------------------------------------------------------------
package reg_file_32x32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : reg_file_32x32_pkg

// File: rtl/reg_file_32x32_if.sv
// ----------------------------------------------------------------------------
// reg_file_32x32_if
// Decode / write-back side bus of the register file.
//   rs1, rs2     : read addresses (decode -> file)
//   rd           : write address  (write-back -> file)
//   regLd        : read enable, capture both read ports on this edge
//   regStr       : write enable, store WBDat into rd on this edge
//   WBDat        : write-back data
//   rs1Out/rs2Out: registered read data (file -> execute)
//   outputValid  : high the cycle after a read edge
// Modports: master drives addresses/enables/data, slave is the register file.
// ----------------------------------------------------------------------------
interface reg_file_32x32_if
    import reg_file_32x32_pkg::*;
#(
    parameter int D_WIDTH = XLEN
);

    reg_addr_t          rs1;
    reg_addr_t          rs2;
    reg_addr_t          rd;
    logic               regLd;
    logic               regStr;
    logic [D_WIDTH-1:0] WBDat;
    logic [D_WIDTH-1:0] rs1Out;
    logic [D_WIDTH-1:0] rs2Out;
    logic               outputValid;

    modport master (
        output rs1, rs2, rd, regLd, regStr, WBDat,
        input  rs1Out, rs2Out, outputValid
    );

    modport slave (
        input  rs1, rs2, rd, regLd, regStr, WBDat,
        output rs1Out, rs2Out, outputValid
    );

endinterface : reg_file_32x32_if

// File: rtl/reg_file_32x32_read_port.sv
// ----------------------------------------------------------------------------
// reg_file_32x32_read_port
// One registered read port: selects an entry of the register view on a load
// edge and holds it otherwise. Address 0 is forced to zero here as well, so
// x0 reads zero regardless of what the view presents at index 0.
//   clk, rst_n : clock, synchronous active-low reset (clears the output)
//   ld_i       : capture enable
//   addr_i     : register specifier
//   regs_i     : current contents of all registers
//   data_o     : registered read data
// ----------------------------------------------------------------------------
module reg_file_32x32_read_port
    import reg_file_32x32_pkg::*;
#(
    parameter int D_WIDTH = XLEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_i,
    input  reg_addr_t          addr_i,
    input  logic [D_WIDTH-1:0] regs_i [NUM_REGS],
    output logic [D_WIDTH-1:0] data_o
);

    logic [D_WIDTH-1:0] data_q;
    logic [D_WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (ld_i) begin
            data_d = (addr_i == '0) ? '0 : regs_i[addr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule : reg_file_32x32_read_port

// File: rtl/reg_file_32x32.sv
// ----------------------------------------------------------------------------
// reg_file_32x32
// RV32 integer register file: 32 x D_WIDTH, two registered read ports, one
// write port, x0 hardwired to zero.
//   clk   : system clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset; clears x1..x31 and all outputs and
//           overrides any read or write in the same cycle
//   bus   : slave side of reg_file_32x32_if (addresses, enables, write data,
//           read data, outputValid)
// Reads sample the register contents before the same-edge write, so a
// read/write collision returns the old value; the new value is seen on the
// next read edge. Every output comes straight from a flop.
// ----------------------------------------------------------------------------
module reg_file_32x32
    import reg_file_32x32_pkg::*;
#(
    parameter int D_WIDTH = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_file_32x32_if.slave   bus
);

    // Storage exists only for x1..x31; x0 is a constant in the read view.
    logic [D_WIDTH-1:0] regs_q   [1:NUM_REGS-1];
    logic [D_WIDTH-1:0] regs_d   [1:NUM_REGS-1];
    logic [D_WIDTH-1:0] reg_view [NUM_REGS];

    logic               valid_q;
    logic               valid_d;
    logic [D_WIDTH-1:0] rs1_data;
    logic [D_WIDTH-1:0] rs2_data;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            assign regs_d[gi]   = (bus.regStr && (bus.rd == reg_addr_t'(gi)))
                                  ? bus.WBDat : regs_q[gi];
            assign reg_view[gi] = regs_q[gi];
        end
    endgenerate

    assign reg_view[0] = '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        valid_d = bus.regLd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    reg_file_32x32_read_port #(
        .D_WIDTH (D_WIDTH)
    ) u_rd_port1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld_i   (bus.regLd),
        .addr_i (bus.rs1),
        .regs_i (reg_view),
        .data_o (rs1_data)
    );

    reg_file_32x32_read_port #(
        .D_WIDTH (D_WIDTH)
    ) u_rd_port2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld_i   (bus.regLd),
        .addr_i (bus.rs2),
        .regs_i (reg_view),
        .data_o (rs2_data)
    );

    assign bus.rs1Out      = rs1_data;
    assign bus.rs2Out      = rs2_data;
    assign bus.outputValid = valid_q;

endmodule : reg_file_32x32

// File: tb/tb_reg_file_32x32.sv
// ----------------------------------------------------------------------------
// tb_reg_file_32x32
// Directed bench for reg_file_32x32. Inputs change 1 time unit after a rising
// edge and are sampled on the next one; outputs are checked 1 unit after the
// edge that should have produced them. Expected register contents are kept in
// a local table written alongside each store.
// ----------------------------------------------------------------------------
module tb_reg_file_32x32;

    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;

    logic [31:0] exp_regs [32];

    reg_file_32x32_if rf_if ();

    reg_file_32x32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Distinct per-register write pattern: byte (A0+i) replicated.
    function automatic logic [31:0] pattern(input int i);
        logic [7:0] b;
        b = 8'(8'hA0 + i);
        return {b, b, b, b};
    endfunction

    // Present a read of (a1, a2), take one edge, check both ports and valid.
    task automatic do_read(input string tag, input int a1, input int a2);
        rf_if.rs1   = 5'(a1);
        rf_if.rs2   = 5'(a2);
        rf_if.regLd = 1'b1;
        tick();
        $display("[TB] read %s rs1=x%0d rs2=x%0d -> %08h %08h valid=%0b",
                 tag, a1, a2, rf_if.rs1Out, rf_if.rs2Out, rf_if.outputValid);
        check_eq({tag, "_rs1"}, rf_if.rs1Out, exp_regs[a1]);
        check_eq({tag, "_rs2"}, rf_if.rs2Out, exp_regs[a2]);
        check_eq({tag, "_valid"}, {31'd0, rf_if.outputValid}, 32'd1);
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        rf_if.regLd  = 1'b0;
        rf_if.regStr = 1'b1;
        rf_if.rd     = 5'(a);
        rf_if.WBDat  = d;
        tick();
        rf_if.regStr = 1'b0;
        if (a != 0) exp_regs[a] = d;
        $display("[TB] write x%0d <= %08h", a, d);
        check_eq("write_valid_low", {31'd0, rf_if.outputValid}, 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;

        rst_n        = 1'b0;
        rf_if.rs1    = '0;
        rf_if.rs2    = '0;
        rf_if.rd     = 5'd7;
        rf_if.regLd  = 1'b0;
        rf_if.regStr = 1'b1;
        rf_if.WBDat  = 32'hdeadbeef;

        // Reset with random read traffic and an attempted write to x7.
        for (int c = 0; c < 10; c++) begin
            rf_if.rs1   = 5'($urandom_range(0, 31));
            rf_if.rs2   = 5'($urandom_range(0, 31));
            rf_if.regLd = 1'($urandom_range(0, 1));
            tick();
            $display("[TB] reset cycle %0d -> %08h %08h valid=%0b",
                     c, rf_if.rs1Out, rf_if.rs2Out, rf_if.outputValid);
            check_eq("rst_rs1", rf_if.rs1Out, 32'd0);
            check_eq("rst_rs2", rf_if.rs2Out, 32'd0);
            check_eq("rst_valid", {31'd0, rf_if.outputValid}, 32'd0);
        end
        rf_if.regStr = 1'b0;
        rst_n        = 1'b1;

        // Write during reset must have been dropped.
        do_read("post_rst", 7, 3);

        // Fill every register, including the x0 attempt.
        do_write(0, 32'hf6f6f6f6);
        for (int i = 1; i < 32; i++) do_write(i, pattern(i));

        do_read("x0", 0, 0);

        // Dual-port reads with different addresses on each port.
        for (int i = 0; i < 16; i++) do_read("dual", i + 1, 2 * i + 1);

        // Full sweep, same address on both ports.
        for (int i = 0; i < 32; i++) do_read("sweep", i, i);

        // Back-to-back writes to the same register: last one wins.
        do_write(3, 32'h11112222);
        do_write(3, 32'h33334444);
        do_read("b2b", 3, 4);

        // Read/write collision on x31: old value first, new value next.
        rf_if.rs1    = 5'd31;
        rf_if.rs2    = 5'd31;
        rf_if.rd     = 5'd31;
        rf_if.regStr = 1'b1;
        rf_if.WBDat  = 32'h0123abcd;
        rf_if.regLd  = 1'b1;
        tick();
        rf_if.regStr = 1'b0;
        $display("[TB] collision x31 -> %08h %08h", rf_if.rs1Out, rf_if.rs2Out);
        check_eq("coll_old_rs1", rf_if.rs1Out, pattern(31));
        check_eq("coll_old_rs2", rf_if.rs2Out, pattern(31));
        exp_regs[31] = 32'h0123abcd;
        do_read("coll_new", 31, 31);

        // Hold: regLd low keeps data, drops valid.
        rf_if.rs1   = 5'd1;
        rf_if.rs2   = 5'd2;
        rf_if.regLd = 1'b0;
        tick();
        $display("[TB] hold -> %08h %08h valid=%0b",
                 rf_if.rs1Out, rf_if.rs2Out, rf_if.outputValid);
        check_eq("hold_rs1", rf_if.rs1Out, 32'h0123abcd);
        check_eq("hold_rs2", rf_if.rs2Out, 32'h0123abcd);
        check_eq("hold_valid", {31'd0, rf_if.outputValid}, 32'd0);

        // Reset mid-operation with a write to x5 and a read in flight.
        rst_n        = 1'b0;
        rf_if.regStr = 1'b1;
        rf_if.rd     = 5'd5;
        rf_if.WBDat  = 32'hcafef00d;
        rf_if.regLd  = 1'b1;
        rf_if.rs1    = 5'd5;
        rf_if.rs2    = 5'd31;
        tick();
        $display("[TB] reset mid-op -> %08h %08h valid=%0b",
                 rf_if.rs1Out, rf_if.rs2Out, rf_if.outputValid);
        check_eq("midrst_rs1", rf_if.rs1Out, 32'd0);
        check_eq("midrst_rs2", rf_if.rs2Out, 32'd0);
        check_eq("midrst_valid", {31'd0, rf_if.outputValid}, 32'd0);
        rst_n        = 1'b1;
        rf_if.regStr = 1'b0;
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
        do_read("after_midrst", 5, 31);
        do_read("after_midrst2", 1, 17);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_reg_file_32x32
